// File: rtl/avr_timer16.sv
// avr_timer16 - I/O-mapped down-counting system timer for the AVR core.
//
// Down-counter with a power-of-two prescaler, periodic/one-shot modes, a
// compare channel, byte-wide atomic access to the wide registers through
// temp bytes, and two maskable interrupt sources merged onto one IRQ line.
//
// Ports:
//   clk    in   1  system clock
//   rst    in   1  synchronous active-high reset
//   io_re  in   1  I/O read strobe (has priority over io_we)
//   io_we  in   1  I/O write strobe
//   io_a   in   3  register select (0 CNTL .. 7 STAT)
//   io_di  in   8  write data
//   io_do  out  8  read data, 8'h00 whenever io_re=0
//   irq    out  1  (OVF & IE_OVF) | (CMPF & IE_CMP)
module avr_timer16 #(
    parameter int          CNT_W    = 16,
    parameter logic [15:0] RST_LOAD = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [2:0] io_a,
    input  logic [7:0] io_di,
    output logic [7:0] io_do,
    output logic       irq
);

    localparam logic [CNT_W-1:0] LOAD_INIT = RST_LOAD[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [7:0]       wtmp_q, wtmp_d;
    logic [7:0]       rtmp_q, rtmp_d;
    logic [6:0]       pre_q, pre_d;
    logic [2:0]       ps_q, ps_d;
    logic             en_q, en_d;
    logic             oneshot_q, oneshot_d;
    logic             ie_ovf_q, ie_ovf_d;
    logic             ie_cmp_q, ie_cmp_d;
    logic             ovf_q, ovf_d;
    logic             cmpf_q, cmpf_d;

    logic             wr;
    logic             tick;
    logic [6:0]       pre_max;
    logic [CNT_W-1:0] cnt_dec;
    logic [15:0]      wdata16;
    logic [15:0]      cnt16, load16, cmp16;
    logic             ovf_set, cmpf_set, ovf_clr, cmpf_clr;

    // A simultaneous read wins, so the write side is simply suppressed.
    assign wr      = io_we & ~io_re;
    // Mask of the low PS bits: 0 for PS=0, 7'h7F for PS=7.
    assign pre_max = ~(7'h7F << ps_q);
    assign tick    = en_q && (pre_q == pre_max);
    assign cnt_dec = cnt_q - CNT_W'(1);
    assign wdata16 = {io_di, wtmp_q};

    // Zero-extended views so bits above CNT_W always read as 0.
    always_comb begin
        cnt16  = '0;
        load16 = '0;
        cmp16  = '0;
        cnt16[CNT_W-1:0]  = cnt_q;
        load16[CNT_W-1:0] = load_q;
        cmp16[CNT_W-1:0]  = cmp_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        load_d    = load_q;
        cmp_d     = cmp_q;
        wtmp_d    = wtmp_q;
        rtmp_d    = rtmp_q;
        pre_d     = pre_q;
        ps_d      = ps_q;
        en_d      = en_q;
        oneshot_d = oneshot_q;
        ie_ovf_d  = ie_ovf_q;
        ie_cmp_d  = ie_cmp_q;
        ovf_set   = 1'b0;
        cmpf_set  = 1'b0;
        ovf_clr   = 1'b0;
        cmpf_clr  = 1'b0;

        if (en_q) begin
            pre_d = tick ? 7'd0 : pre_q + 7'd1;
        end

        if (tick) begin
            if (cnt_q == '0) begin
                cnt_d   = load_q;
                ovf_set = 1'b1;
                if (oneshot_q) begin
                    en_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_dec;
                if (cnt_dec == cmp_q) begin
                    cmpf_set = 1'b1;
                end
            end
        end

        // Snapshot the high byte alongside the low-byte read.
        if (io_re && io_a == 3'd0) begin
            rtmp_d = cnt16[15:8];
        end

        // Bus writes come after the tick logic so they override it.
        if (wr) begin
            case (io_a)
                3'd0: begin
                    // Restart cancels any tick in the same cycle, flags included.
                    cnt_d    = load_q;
                    pre_d    = 7'd0;
                    ovf_set  = 1'b0;
                    cmpf_set = 1'b0;
                    en_d     = en_q;
                end
                3'd2: wtmp_d = io_di;
                3'd3: load_d = wdata16[CNT_W-1:0];
                3'd4: wtmp_d = io_di;
                3'd5: cmp_d  = wdata16[CNT_W-1:0];
                3'd6: begin
                    en_d      = io_di[0];
                    oneshot_d = io_di[1];
                    ie_ovf_d  = io_di[2];
                    ie_cmp_d  = io_di[3];
                    ps_d      = io_di[6:4];
                end
                3'd7: begin
                    ovf_clr  = io_di[0];
                    cmpf_clr = io_di[1];
                end
                default: ;
            endcase
        end

        // Hardware set beats a same-cycle W1C.
        ovf_d  = (ovf_q & ~ovf_clr) | ovf_set;
        cmpf_d = (cmpf_q & ~cmpf_clr) | cmpf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            load_q    <= LOAD_INIT;
            cmp_q     <= '0;
            wtmp_q    <= 8'h00;
            rtmp_q    <= 8'h00;
            pre_q     <= 7'd0;
            ps_q      <= 3'd0;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            ie_ovf_q  <= 1'b0;
            ie_cmp_q  <= 1'b0;
            ovf_q     <= 1'b0;
            cmpf_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            cmp_q     <= cmp_d;
            wtmp_q    <= wtmp_d;
            rtmp_q    <= rtmp_d;
            pre_q     <= pre_d;
            ps_q      <= ps_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            ie_ovf_q  <= ie_ovf_d;
            ie_cmp_q  <= ie_cmp_d;
            ovf_q     <= ovf_d;
            cmpf_q    <= cmpf_d;
        end
    end

    always_comb begin
        io_do = 8'h00;
        if (io_re) begin
            case (io_a)
                3'd0: io_do = cnt16[7:0];
                3'd1: io_do = rtmp_q;
                3'd2: io_do = load16[7:0];
                3'd3: io_do = load16[15:8];
                3'd4: io_do = cmp16[7:0];
                3'd5: io_do = cmp16[15:8];
                3'd6: io_do = {1'b0, ps_q, ie_cmp_q, ie_ovf_q, oneshot_q, en_q};
                3'd7: io_do = {6'b0, cmpf_q, ovf_q};
                default: io_do = 8'h00;
            endcase
        end
    end

    assign irq = (ovf_q & ie_ovf_q) | (cmpf_q & ie_cmp_q);

endmodule

// File: tb/tb_avr_timer16.sv
module tb_avr_timer16;

    logic       clk;
    logic       rst;
    logic       io_re;
    logic       io_we;
    logic [2:0] io_a;
    logic [7:0] io_di;
    logic [7:0] io_do;
    logic       irq;
    logic [7:0] io_do12;
    logic       irq12;

    int errors = 0;
    int checks = 0;

    avr_timer16 dut (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we),
        .io_a(io_a), .io_di(io_di), .io_do(io_do), .irq(irq)
    );

    avr_timer16 #(.CNT_W(12)) dut12 (
        .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we),
        .io_a(io_a), .io_di(io_di), .io_do(io_do12), .irq(irq12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // All bus tasks start and end on a negedge and consume exactly one posedge.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        io_we = 1'b1;
        io_a  = a;
        io_di = d;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d, output logic [7:0] d12);
        io_re = 1'b1;
        io_a  = a;
        #1;
        d   = io_do;
        d12 = io_do12;
        @(negedge clk);
        io_re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] d, d12;
        logic [7:0] exp_rd [8];
        exp_rd = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_a = 3'd0; io_di = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d, d12);
            checks++;
            if (d !== exp_rd[a]) begin
                errors++;
                $display("FAIL reset_read a=%0d: got %h want %h", a, d, exp_rd[a]);
            end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        for (int a = 0; a < 8; a++) begin
            io_a = 3'(a);
            #1;
            checks++;
            if (io_do !== 8'h00) begin
                errors++;
                $display("FAIL idle_do a=%0d: got %h want 00", a, io_do);
            end
        end
        @(negedge clk);
        rd(3'd3, d, d12);
        checks++;
        if (d12 !== 8'h0F) begin errors++; $display("FAIL w12_reset_loadh: got %h want 0f", d12); end
    endtask

    task automatic test_periodic;
        logic [7:0] d, d12;
        logic [7:0] exp_cnt;
        wr(3'd2, 8'h03); wr(3'd3, 8'h00); wr(3'd0, 8'h00); wr(3'd6, 8'h05);
        io_re = 1'b1; io_a = 3'd0;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_cnt = 8'(3 - (i % 4));
            checks++;
            if (io_do !== exp_cnt) begin
                errors++;
                $display("FAIL periodic_cnt i=%0d: got %h want %h", i, io_do, exp_cnt);
            end
            checks++;
            if (irq !== (i >= 4)) begin
                errors++;
                $display("FAIL periodic_irq i=%0d: got %b want %b", i, irq, (i >= 4));
            end
            @(negedge clk);
        end
        io_re = 1'b0;
        wr(3'd7, 8'h01);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq); end
        idle(2);
        wr(3'd7, 8'h01);
        #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_vs_set_irq: got %b want 1", irq); end
        rd(3'd7, d, d12);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL w1c_vs_set_stat: got %h want 03", d); end
        wr(3'd6, 8'h00); wr(3'd7, 8'h03);
    endtask

    task automatic test_oneshot;
        logic [7:0] d, d12;
        logic [7:0] exp_cnt;
        wr(3'd2, 8'h02); wr(3'd3, 8'h00); wr(3'd0, 8'h00); wr(3'd6, 8'h33);
        io_re = 1'b1; io_a = 3'd0;
        for (int i = 0; i < 28; i++) begin
            #1;
            exp_cnt = (i < 8) ? 8'h02 : (i < 16) ? 8'h01 : (i < 24) ? 8'h00 : 8'h02;
            checks++;
            if (io_do !== exp_cnt) begin
                errors++;
                $display("FAIL oneshot_cnt i=%0d: got %h want %h", i, io_do, exp_cnt);
            end
            @(negedge clk);
        end
        io_re = 1'b0;
        rd(3'd6, d, d12);
        checks++;
        if (d !== 8'h32) begin errors++; $display("FAIL oneshot_ctrl: got %h want 32", d); end
        rd(3'd7, d, d12);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL oneshot_stat: got %h want 03", d); end
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq: got %b want 0", irq); end
        idle(20);
        rd(3'd0, d, d12);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL oneshot_hold: got %h want 02", d); end
        wr(3'd7, 8'h03);
    endtask

    task automatic test_compare;
        logic [7:0] d, d12;
        wr(3'd2, 8'h00); wr(3'd3, 8'h01); wr(3'd4, 8'h80); wr(3'd5, 8'h00);
        wr(3'd0, 8'h00); wr(3'd6, 8'h09);
        idle(127);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL cmp_before: got %b want 0", irq); end
        idle(1);
        #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL cmp_hit_irq: got %b want 1", irq); end
        rd(3'd7, d, d12);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL cmp_hit_stat: got %h want 02", d); end
        wr(3'd6, 8'h01);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL cmp_mask_irq: got %b want 0", irq); end
        rd(3'd7, d, d12);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL cmp_mask_stat: got %h want 02", d); end
        wr(3'd6, 8'h00); wr(3'd7, 8'h02);
        rd(3'd7, d, d12);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL cmp_clear_stat: got %h want 00", d); end
    endtask

    task automatic test_snapshot;
        logic [7:0] d, d12;
        wr(3'd2, 8'h02); wr(3'd3, 8'h01); wr(3'd0, 8'h00); wr(3'd6, 8'h01);
        rd(3'd0, d, d12);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL snap_lo: got %h want 02", d); end
        idle(5);
        rd(3'd1, d, d12);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL snap_hi: got %h want 01", d); end
        wr(3'd6, 8'h00);
    endtask

    task automatic test_load_atomic;
        logic [7:0] d, d12;
        wr(3'd2, 8'h05); wr(3'd3, 8'h00); wr(3'd0, 8'h00);
        wr(3'd2, 8'h34); wr(3'd6, 8'h01);
        idle(6);
        rd(3'd0, d, d12);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL loadl_only_reload: got %h want 05", d); end
        wr(3'd3, 8'h12);
        idle(4);
        rd(3'd0, d, d12);
        checks++;
        if (d !== 8'h34) begin errors++; $display("FAIL new_reload_lo: got %h want 34", d); end
        rd(3'd1, d, d12);
        checks++;
        if (d !== 8'h12) begin errors++; $display("FAIL new_reload_hi: got %h want 12", d); end
        checks++;
        if (d12 !== 8'h02) begin errors++; $display("FAIL w12_cnth: got %h want 02", d12); end
        rd(3'd3, d, d12);
        checks++;
        if (d !== 8'h12) begin errors++; $display("FAIL loadh: got %h want 12", d); end
        checks++;
        if (d12 !== 8'h02) begin errors++; $display("FAIL w12_loadh: got %h want 02", d12); end
        wr(3'd6, 8'h00);
    endtask

    task automatic test_back_to_back;
        logic [7:0] d, d12;
        wr(3'd7, 8'h03);
        wr(3'd2, 8'h02); wr(3'd3, 8'h00); wr(3'd0, 8'h00); wr(3'd6, 8'h01);
        idle(2);
        wr(3'd0, 8'h00);
        rd(3'd0, d, d12);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL restart_vs_tick_cnt: got %h want 02", d); end
        rd(3'd7, d, d12);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL restart_vs_tick_stat: got %h want 00", d); end
        wr(3'd0, 8'h00);
        wr(3'd6, 8'h03);
        idle(1);
        wr(3'd6, 8'h07);
        rd(3'd6, d, d12);
        checks++;
        if (d !== 8'h07) begin errors++; $display("FAIL ctrl_vs_autoclr: got %h want 07", d); end
        rd(3'd7, d, d12);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL ctrl_vs_autoclr_stat: got %h want 01", d); end
        wr(3'd6, 8'h00); wr(3'd7, 8'h03);
    endtask

    task automatic test_rw_conflict;
        logic [7:0] d, d12;
        io_re = 1'b1; io_we = 1'b1; io_a = 3'd6; io_di = 8'h01;
        @(negedge clk);
        io_re = 1'b0; io_we = 1'b0;
        rd(3'd6, d, d12);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rw_conflict: got %h want 00", d); end
    endtask

    task automatic test_reset_midflight;
        logic [7:0] d, d12;
        wr(3'd4, 8'hAA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(3'd5, 8'h00);
        rd(3'd4, d, d12);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL wtmp_lost: got %h want 00", d); end
        rd(3'd2, d, d12);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL rst_loadl: got %h want ff", d); end
        rd(3'd0, d, d12);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rst_cnt: got %h want 00", d); end
    endtask

    initial begin
        rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_a = 3'd0; io_di = 8'h00;
        @(negedge clk);
        test_reset;
        test_periodic;
        test_oneshot;
        test_compare;
        test_snapshot;
        test_load_atomic;
        test_back_to_back;
        test_rw_conflict;
        test_reset_midflight;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
